// File: rtl/key_click_decoder.sv
// Groups single-cycle key press pulses into bursts and reports click counts.
// Define KEY_CLICK_OVERRUN_EN to add the sticky overrun output.
module key_click_decoder #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int GAP_MS     = 300,
  parameter int MAX_CLICKS = 3,
  localparam int CW        = $clog2(MAX_CLICKS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          press,
  output logic          click_valid,
  input  logic          click_ready,
`ifdef KEY_CLICK_OVERRUN_EN
  output logic          overrun,
`endif
  output logic [CW-1:0] click_count
);

  localparam int GAP_CYC = (CLK_HZ / 1000) * GAP_MS;
  localparam int TW      = $clog2(GAP_CYC);

  localparam logic [TW-1:0] T_LAST = TW'(GAP_CYC - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_CLICKS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] fin_val;
  logic          fin;
  logic          slot_free;

  assign cnt_inc   = cnt_q + C_ONE;
  assign slot_free = !valid_q || click_ready;

  // Burst counting: a press always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    fin     = 1'b0;
    fin_val = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          cnt_d   = C_ONE;
          timer_d = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (press) begin
          timer_d = '0;
          cnt_d   = cnt_inc;
          if (cnt_inc == C_MAX) begin
            fin     = 1'b1;
            fin_val = C_MAX;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (timer_q == T_LAST) begin
          fin     = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (fin && slot_free) begin
      valid_d = 1'b1;
      count_d = fin_val;
    end else if (valid_q && click_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef KEY_CLICK_OVERRUN_EN
  logic ovr_q, ovr_d;

  assign ovr_d   = ovr_q || (fin && !slot_free);
  assign overrun = ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end
`endif

  assign click_valid = valid_q;
  assign click_count = count_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder: directed plan scenarios plus random presses
// compared against an edge-time based burst model.
module tb_key_click_decoder;

  localparam int CLK_HZ = 1000;
  localparam int GAP_MS = 4;
  localparam int GAP    = 4;
  localparam int MAXC   = 3;
  localparam int CW     = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          press = 1'b0;
  logic          click_ready = 1'b0;
  logic          click_valid;
  logic [CW-1:0] click_count;
`ifdef KEY_CLICK_OVERRUN_EN
  logic          overrun;
`endif

  key_click_decoder #(
    .CLK_HZ    (CLK_HZ),
    .GAP_MS    (GAP_MS),
    .MAX_CLICKS(MAXC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .press      (press),
    .click_valid(click_valid),
    .click_ready(click_ready),
`ifdef KEY_CLICK_OVERRUN_EN
    .overrun    (overrun),
`endif
    .click_count(click_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Model: burst size, edge of last press, and the output slot.
  int m_cnt   = 0;
  int m_last  = 0;
  bit m_valid = 0;
  int m_count = 0;
  bit m_ovr   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit p, input bit r, input bit rst = 1'b1);
    press       = p;
    click_ready = r;
    rst_n       = rst;
    @(posedge clk);
    edge_n++;
    if (!rst) begin
      m_cnt   = 0;
      m_valid = 0;
      m_count = 0;
      m_ovr   = 0;
    end else begin
      bit fin;
      int val;
      bit free;
      fin  = 0;
      val  = 0;
      free = !m_valid || r;
      if (m_cnt == 0) begin
        if (p) begin
          m_cnt  = 1;
          m_last = edge_n;
        end
      end else if (p) begin
        m_cnt++;
        m_last = edge_n;
        if (m_cnt == MAXC) begin
          fin   = 1;
          val   = MAXC;
          m_cnt = 0;
        end
      end else if (edge_n - m_last == GAP) begin
        fin   = 1;
        val   = m_cnt;
        m_cnt = 0;
      end
      if (fin && free) begin
        m_valid = 1;
        m_count = val;
      end else begin
        if (fin) m_ovr = 1;
        if (m_valid && r) m_valid = 0;
      end
    end
    #1;
    chk("valid", 32'(click_valid), 32'(m_valid));
    chk("count", 32'(click_count), 32'(m_count));
`ifdef KEY_CLICK_OVERRUN_EN
    chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
  endtask

  // Reset, then press on the listed relative edges with ready held;
  // at edge exp_e the report exp_c must be showing.
  task automatic scen(input int pe[4], input int n, input bit r,
                      input int exp_e, input int exp_c);
    step(1'b0, r, 1'b0);
    chk("rst_valid", 32'(click_valid), 32'd0);
    chk("rst_count", 32'(click_count), 32'd0);
    for (int rel = 1; rel <= n; rel++) begin
      bit p;
      p = 0;
      for (int k = 0; k < 4; k++) if (pe[k] == rel) p = 1;
      step(p, r);
      if (rel == exp_e - 1) chk("pre_report", 32'(click_valid), 32'd0);
      if (rel == exp_e) begin
        chk("report_valid", 32'(click_valid), 32'd1);
        chk("report_count", 32'(click_count), 32'(exp_c));
      end
      if (rel == exp_e + 1) chk("cleared", 32'(click_valid), 32'd0);
    end
  endtask

  initial begin
    // Single press, timeout path.
    scen('{10, -1, -1, -1}, 20, 1'b1, 14, 1);
    // Double press, report after gap from the second.
    scen('{10, 13, -1, -1}, 22, 1'b1, 17, 2);
    // Triple press ends early; next press starts a new burst.
    scen('{10, 12, 14, -1}, 14, 1'b1, 14, 3);
    for (int rel = 15; rel <= 22; rel++) begin
      step(rel == 15, 1'b1);
      if (rel == 19) begin
        chk("after_max_valid", 32'(click_valid), 32'd1);
        chk("after_max_count", 32'(click_count), 32'd1);
      end
    end
    // Press coincides with timeout: burst extends.
    scen('{10, 14, -1, -1}, 24, 1'b1, 18, 2);

    // Backpressure, drop, accept, same-edge accept plus finish.
    step(1'b0, 1'b0, 1'b0);
    for (int rel = 1; rel <= 55; rel++) begin
      bit p, r;
      p = (rel == 10) || (rel == 20) || (rel == 22) || (rel == 34) ||
          (rel == 40) || (rel == 42);
      r = (rel >= 30 && rel <= 33) || (rel == 46) || (rel >= 50);
      step(p, r);
      if (rel == 26) begin
        chk("held_valid", 32'(click_valid), 32'd1);
        chk("held_count", 32'(click_count), 32'd1);
`ifdef KEY_CLICK_OVERRUN_EN
        chk("ovr_set", 32'(overrun), 32'd1);
`endif
      end
      if (rel == 31) chk("accept_clr", 32'(click_valid), 32'd0);
      if (rel == 46 || rel == 47) begin
        chk("b2b_valid", 32'(click_valid), 32'd1);
        chk("b2b_count", 32'(click_count), 32'd2);
      end
    end

    // Reset mid-burst discards it.
    step(1'b0, 1'b1, 1'b0);
    for (int rel = 1; rel <= 26; rel++) begin
      step(rel == 10 || rel == 20, 1'b1, rel != 12);
      if (rel == 16) chk("discard", 32'(click_valid), 32'd0);
      if (rel == 24) begin
        chk("post_rst_valid", 32'(click_valid), 32'd1);
        chk("post_rst_count", 32'(click_count), 32'd1);
      end
    end

    // Random presses, ready and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
